// File: rtl/dot_prod_engine.sv
// dot_prod_engine
//   Pipelined signed dot-product engine:
//     result = acc_init + sum(a[i]*b[i]) for i in [i_init, min(i_end, DEPTH))
//   Two single-port operand memories (a, b) are owned by the host when idle
//   and by the engine while a run is in progress.
//
//   Optional feature macro: DOT_PROD_SAT_EN
//     defined   -> saturating accumulate (clamp to the ACC_W signed limits)
//     undefined -> two's-complement wrap
//   In both builds, 'overflow' is set when an accumulate overflows.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a run (accepted only in IDLE or DONE)
//   i_init, i_end, acc_init    run parameters, latched on an accepted start
//   host_sel                   host owns both memories (when not busy)
//   host_we_*, host_addr_*,
//   host_wdata_*               host write/read port per memory
//   host_rdata_*               host read data, 1-cycle latency, 0 when not owned
//   busy                       run in progress (FETCH/DRAIN)
//   done                       result valid; held until the next accepted start
//   overflow                   sticky per run: signed accumulate overflow seen
//   result                     final sum
module dot_prod_engine #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 1000,
  parameter int ACC_W  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        i_init,
  input  logic [ADDR_W:0]          i_end,
  input  logic signed [ACC_W-1:0]  acc_init,
  input  logic                     host_sel,
  input  logic                     host_we_a,
  input  logic                     host_we_b,
  input  logic [ADDR_W-1:0]        host_addr_a,
  input  logic [ADDR_W-1:0]        host_addr_b,
  input  logic signed [DATA_W-1:0] host_wdata_a,
  input  logic signed [DATA_W-1:0] host_wdata_b,
  output logic signed [DATA_W-1:0] host_rdata_a,
  output logic signed [DATA_W-1:0] host_rdata_b,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic signed [ACC_W-1:0]  result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic              drain_cnt_q;

  logic [ADDR_W:0]   end_clamped;
  logic              run_nonempty;
  logic              start_ok;
  logic [ADDR_W-1:0] last_d;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    end_clamped  = (i_end > DEPTH_C) ? DEPTH_C : i_end;
    run_nonempty = ({1'b0, i_init} < end_clamped);
    start_ok     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // Only meaningful for a non-empty run, where end_clamped >= 1.
    last_d       = ADDR_W'(end_clamped - (ADDR_W+1)'(1));
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      last_q      <= '0;
      drain_cnt_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            addr_q      <= i_init;
            last_q      <= last_d;
            drain_cnt_q <= 1'b0;
            if (run_nonempty) begin
              state_q <= S_FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Empty range: result is acc_init, done from the next cycle.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (addr_q == last_q) begin
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Two cycles let the last index pass the read and product stages;
          // the final accumulate lands on the edge that enters DONE.
          if (drain_cnt_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand memories: engine owns the address while busy, host otherwise.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] mem_a [DEPTH];
  logic signed [DATA_W-1:0] mem_b [DEPTH];
  logic signed [DATA_W-1:0] rd_a_q;
  logic signed [DATA_W-1:0] rd_b_q;
  logic [ADDR_W-1:0]        mem_addr_a;
  logic [ADDR_W-1:0]        mem_addr_b;
  logic                     mem_we_a;
  logic                     mem_we_b;
  logic                     host_own;
  logic                     host_rd_vld_q;

  always_comb begin
    host_own   = host_sel && !busy_q;
    mem_addr_a = busy_q ? addr_q : host_addr_a;
    mem_addr_b = busy_q ? addr_q : host_addr_b;
    mem_we_a   = host_own && host_we_a;
    mem_we_b   = host_own && host_we_b;
  end

  // NOTE: the memory arrays and their read registers have no reset; contents
  // must survive rst_n, and the read data is qualified by separate valid bits.
  always_ff @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= host_wdata_a;
    if (mem_we_b) mem_b[mem_addr_b] <= host_wdata_b;
    rd_a_q <= mem_a[mem_addr_a];
    rd_b_q <= mem_b[mem_addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rd_vld_q <= 1'b0;
    else        host_rd_vld_q <= host_own;
  end

  // Read data is shown only for a host-owned read issued last cycle, and only
  // while the host still owns the memories.
  assign host_rdata_a = (host_rd_vld_q && host_own) ? rd_a_q : '0;
  assign host_rdata_b = (host_rd_vld_q && host_own) ? rd_b_q : '0;

  // ---------------------------------------------------------------------------
  // MAC pipeline: read (stage 0->1), product (stage 1), accumulate (stage 2)
  // ---------------------------------------------------------------------------
  logic                       rd_vld_q;
  logic                       prod_vld_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic signed [2*DATA_W-1:0] prod_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       add_ovf;
  logic                       ovf_q;

`ifdef DOT_PROD_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  always_comb begin
    prod_d   = (2*DATA_W)'(rd_a_q) * (2*DATA_W)'(rd_b_q);
    prod_ext = ACC_W'(prod_q);
    sum      = acc_q + prod_ext;
    // Overflow: same-sign addends produced a sum of the other sign.
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef DOT_PROD_SAT_EN
    // Clamp towards the sign of the addends; later opposite-sign products
    // continue from the clamped value.
    acc_d = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    acc_d = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rd_vld_q   <= (state_q == S_FETCH);
      prod_vld_q <= rd_vld_q;
      if (rd_vld_q) prod_q <= prod_d;
      if (start_ok) begin
        acc_q <= acc_init;
        ovf_q <= 1'b0;
      end else if (prod_vld_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | add_ovf;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign result   = acc_q;

endmodule

// File: tb/tb_dot_prod_engine.sv
// tb_dot_prod_engine
//   Scoreboard bench for dot_prod_engine (default parameters). The driver
//   pushes the expected result/overflow/latency of every accepted run, computed
//   by an exact-arithmetic reference model; a monitor pops and compares when
//   'done' is presented. Honours DOT_PROD_SAT_EN like the design.
module tb_dot_prod_engine;

  localparam int DATA_W = 27;
  localparam int DEPTH  = 1000;
  localparam int ACC_W  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [ADDR_W-1:0]        i_init;
  logic [ADDR_W:0]          i_end;
  logic signed [ACC_W-1:0]  acc_init;
  logic                     host_sel;
  logic                     host_we_a;
  logic                     host_we_b;
  logic [ADDR_W-1:0]        host_addr_a;
  logic [ADDR_W-1:0]        host_addr_b;
  logic signed [DATA_W-1:0] host_wdata_a;
  logic signed [DATA_W-1:0] host_wdata_b;
  logic signed [DATA_W-1:0] host_rdata_a;
  logic signed [DATA_W-1:0] host_rdata_b;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic signed [ACC_W-1:0]  result;

  dot_prod_engine #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .i_init       (i_init),
    .i_end        (i_end),
    .acc_init     (acc_init),
    .host_sel     (host_sel),
    .host_we_a    (host_we_a),
    .host_we_b    (host_we_b),
    .host_addr_a  (host_addr_a),
    .host_addr_b  (host_addr_b),
    .host_wdata_a (host_wdata_a),
    .host_wdata_b (host_wdata_b),
    .host_rdata_a (host_rdata_a),
    .host_rdata_b (host_rdata_b),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [127:0] act,
                       input logic signed [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: memory image plus exact (128-bit) arithmetic.
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] ma [DEPTH];
  logic signed [DATA_W-1:0] mb [DEPTH];

  typedef struct {
    logic signed [ACC_W-1:0] res;
    logic                    ovf;
    int                      c0;
    int                      lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  function automatic void model(input int i0, input int ie,
                                input logic signed [ACC_W-1:0] ai,
                                output logic signed [ACC_W-1:0] res,
                                output logic ovf, output int lat);
    logic signed [127:0] amax, amin, acc, s;
    int hi;
    amax = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
    amin = -amax - 128'sd1;
    hi   = (ie > DEPTH) ? DEPTH : ie;
    acc  = ai;
    ovf  = 1'b0;
    for (int i = i0; i < hi; i++) begin
      s = acc + ma[i] * mb[i];
      if (s > amax || s < amin) begin
        ovf = 1'b1;
`ifdef DOT_PROD_SAT_EN
        acc = (s > amax) ? amax : amin;
`else
        acc = $signed(s[ACC_W-1:0]);
`endif
      end else begin
        acc = s;
      end
    end
    res = acc[ACC_W-1:0];
    lat = (hi - i0 >= 1) ? (hi - i0 + 3) : 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares whenever the DUT presents a result.
  // ---------------------------------------------------------------------------
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      if (done && sb.size() != 0) begin
        e = sb.pop_front();
        check("result",   result,           e.res);
        check("overflow", overflow,         e.ovf);
        check("latency",  cyc - e.c0,       e.lat);
        check("busy_at_done", busy,         1'b0);
      end else if (done && !done_prev) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no result", cyc);
      end
      done_prev <= done;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic hwrite(input int addr, input logic signed [DATA_W-1:0] da,
                        input logic signed [DATA_W-1:0] db);
    @(negedge clk);
    host_sel     = 1'b1;
    host_we_a    = 1'b1;
    host_we_b    = 1'b1;
    host_addr_a  = ADDR_W'(addr);
    host_addr_b  = ADDR_W'(addr);
    host_wdata_a = da;
    host_wdata_b = db;
    @(posedge clk);
    #1;
    host_we_a = 1'b0;
    host_we_b = 1'b0;
    ma[addr] = da;
    mb[addr] = db;
  endtask

  task automatic hread(input int addr, input string name);
    @(negedge clk);
    host_sel    = 1'b1;
    host_we_a   = 1'b0;
    host_we_b   = 1'b0;
    host_addr_a = ADDR_W'(addr);
    host_addr_b = ADDR_W'(addr);
    @(negedge clk);
    check({name, "_a"}, host_rdata_a, ma[addr]);
    check({name, "_b"}, host_rdata_b, mb[addr]);
  endtask

  // Drives start right away; caller is positioned away from the rising edge.
  task automatic run(input int i0, input int ie, input logic signed [ACC_W-1:0] ai);
    exp_t x;
    start    = 1'b1;
    i_init   = ADDR_W'(i0);
    i_end    = (ADDR_W+1)'(ie);
    acc_init = ai;
    @(posedge clk);
    #1;
    start = 1'b0;
    model(i0, ie, ai, x.res, x.ovf, x.lat);
    x.c0 = cyc - 1;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_timeout: got no done within %0d cycles, expected done", budget);
      sb.delete();
    end
  endtask

  function automatic logic signed [DATA_W-1:0] rnd_data();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return {1'b1, {(DATA_W-1){1'b0}}};
    if (sel == 1) return {1'b0, {(DATA_W-1){1'b1}}};
    return DATA_W'($urandom);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

  initial begin
    logic signed [DATA_W-1:0] neg_ext;
    logic signed [ACC_W-1:0]  ai;
    int i0, ie;

    neg_ext      = {1'b1, {(DATA_W-1){1'b0}}};
    rst_n        = 1'b0;
    start        = 1'b0;
    i_init       = '0;
    i_end        = '0;
    acc_init     = '0;
    host_sel     = 1'b0;
    host_we_a    = 1'b0;
    host_we_b    = 1'b0;
    host_addr_a  = '0;
    host_addr_b  = '0;
    host_wdata_a = '0;
    host_wdata_b = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_result",   result,   0);

    // a[k] = k, b[k] = 1
    for (int k = 0; k < DEPTH; k++) hwrite(k, DATA_W'(k), DATA_W'(1));
    hread(7, "idle_read");
    hread(999, "idle_read_top");

    // Full-length run
    run(0, 1000, 0);
    wait_idle(1200);

    // Reset mid-run, then reproduce the full result
    run(0, 1000, 0);
    repeat (49) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     busy,     1'b0);
    check("midrst_done",     done,     1'b0);
    check("midrst_result",   result,   0);
    check("midrst_overflow", overflow, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1000, 0);
    wait_idle(1200);

    // Empty range, then a back-to-back start in the first DONE cycle
    run(5, 5, -7);
    wait_idle(10);
    run(10, 20, 3);
    wait_idle(40);
    run(900, 3, 1);          // i_init beyond i_end: empty
    wait_idle(10);

    // Mid-run: ignored start, dropped host write, gated read data
    @(negedge clk);
    run(0, 1000, 42);
    repeat (10) @(negedge clk);
    start        = 1'b1;
    i_init       = ADDR_W'(2);
    i_end        = (ADDR_W+1)'(5);
    acc_init     = 99;
    host_sel     = 1'b1;
    host_we_a    = 1'b1;
    host_addr_a  = ADDR_W'(3);
    host_addr_b  = ADDR_W'(3);
    host_wdata_a = DATA_W'(12345);
    @(negedge clk);
    start     = 1'b0;
    host_we_a = 1'b0;
    check("busy_rdata_a", host_rdata_a, 0);
    check("busy_rdata_b", host_rdata_b, 0);
    check("busy_high", busy, 1'b1);
    wait_idle(1200);
    hread(3, "dropped_write");

    // Overflow: positive, saturate/wrap then opposite-sign product, negative
    hwrite(0, DATA_W'(1), DATA_W'(1));
    hwrite(1, DATA_W'(3), -DATA_W'(5));
    run(0, 1, AMAX);
    wait_idle(20);
    run(0, 2, AMAX);
    wait_idle(20);
    run(1, 2, AMIN);
    wait_idle(20);
    run(1, 2, AMIN + 64'sd15);   // exactly reaches the minimum: no overflow
    wait_idle(20);

    // Extremes: (-2^26)^2 three times, and a clamped i_end
    for (int k = 0; k < 3; k++) hwrite(k, neg_ext, neg_ext);
    run(0, 3, 10);
    wait_idle(20);
    check("extreme_sum", result, (64'sd3 <<< 52) + 64'sd10);
    run(998, 1200, -5);
    wait_idle(20);

    // Randomized memory image and runs
    for (int k = 0; k < DEPTH; k++) hwrite(k, rnd_data(), rnd_data());
    for (int r = 0; r < 4; r++) hread($urandom_range(0, DEPTH-1), "rand_read");
    for (int r = 0; r < 16; r++) begin
      i0 = $urandom_range(0, 1023);
      ie = (r % 4 == 0) ? $urandom_range(0, 2047) : i0 + $urandom_range(0, 120);
      if (ie > 2047) ie = 2047;
      if (r % 3 == 0) ai = {$urandom, $urandom};
      else            ai = ACC_W'($signed($urandom_range(0, 2000)) - 1000);
      run(i0, ie, ai);
      wait_idle(1200);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
